// File: rtl/spi_pkg.sv
// Shared SPI slave types: shift-register mode encodings, controller states, default frame width.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_RIGHT = 2'b01,
    SR_LEFT  = 2'b10,
    SR_PLOAD = 2'b11
  } srMode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DECODE,
    ST_RD_WAIT,
    ST_RD_LOAD,
    ST_RD_SHIFT,
    ST_WR_SHIFT,
    ST_WR_COMMIT,
    ST_DONE
  } state_t;

  function automatic logic isShift(input state_t s);
    return (s == ST_ADDR) || (s == ST_RD_SHIFT) || (s == ST_WR_SHIFT);
  endfunction

  function automatic srMode_t modeOf(input state_t s);
    case (s)
      ST_ADDR, ST_RD_SHIFT, ST_WR_SHIFT: return SR_LEFT;
      ST_RD_LOAD:                        return SR_PLOAD;
      default:                           return SR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/spi_fsm_if.sv
// Handshake bundle between the SPI transaction controller and its neighbours.
// addr_inc exists only when SPI_FSM_BURST_EN is defined.
interface spi_fsm_if;
  logic       cs_n;
  logic       sclk_posedge;
  logic       rw_bit;
  logic [1:0] sr_mode;
  logic       sr_tick;
  logic       addr_we;
  logic       dm_we;
  logic       miso_oe;
  logic       frame_err;
`ifdef SPI_FSM_BURST_EN
  logic       addr_inc;
`else
`endif

  modport slave (
    input  cs_n, sclk_posedge, rw_bit,
`ifdef SPI_FSM_BURST_EN
    output addr_inc,
`else
`endif
    output sr_mode, sr_tick, addr_we, dm_we, miso_oe, frame_err
  );

  modport master (
    output cs_n, sclk_posedge, rw_bit,
`ifdef SPI_FSM_BURST_EN
    input  addr_inc,
`else
`endif
    input  sr_mode, sr_tick, addr_we, dm_we, miso_oe, frame_err
  );
endinterface

// File: rtl/spi_bit_counter.sv
// Clearable SCLK edge counter; tc flags the edge that completes a WIDTH-bit frame.
module spi_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         en,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         tc
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = en && (count == CW'(WIDTH - 1));
endmodule

// File: rtl/spi_fsm.sv
// SPI memory-slave transaction controller (Moore, registered outputs).
// Optional burst mode via SPI_FSM_BURST_EN adds addr_inc and auto-advancing frames.
module spi_fsm
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = SPI_WIDTH,
  parameter int unsigned MEM_LAT = 1
) (
  input logic      clk,
  input logic      reset_n,
  spi_fsm_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned LW = 3;

  state_t        state;
  state_t        nextState;
  logic [LW-1:0] latCnt;
  logic [CW-1:0] bitCount;
  logic          cntEn;
  logic          cntClr;
  logic          lastEdge;
  logic          abort;
  logic          errQuiet;

  srMode_t srModeQ;
  logic    srTickQ;
  logic    addrWeQ;
  logic    dmWeQ;
  logic    misoOeQ;
  logic    frameErrQ;

  assign abort  = bus.cs_n && !(state inside {ST_IDLE, ST_DONE});
  assign cntEn  = isShift(state) && bus.sclk_posedge && !bus.cs_n;
  assign cntClr = (nextState != state);

  spi_bit_counter #(.WIDTH(WIDTH)) bitCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cntClr),
    .en      (cntEn),
    .count   (bitCount),
    .tc      (lastEdge)
  );

`ifdef SPI_FSM_BURST_EN
  logic addrIncQ;
  // Between bytes of a burst, releasing cs_n is the normal way to end it.
  assign errQuiet     = (bitCount == '0) && !(state inside {ST_ADDR, ST_DECODE});
  assign bus.addr_inc = addrIncQ;
`else
  assign errQuiet = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:      if (!bus.cs_n) nextState = ST_ADDR;
      ST_ADDR:      if (lastEdge) nextState = ST_DECODE;
      ST_DECODE:    nextState = bus.rw_bit ? ST_RD_WAIT : ST_WR_SHIFT;
      ST_RD_WAIT:   if (latCnt == LW'(MEM_LAT - 1)) nextState = ST_RD_LOAD;
      ST_RD_LOAD:   nextState = ST_RD_SHIFT;
`ifdef SPI_FSM_BURST_EN
      ST_RD_SHIFT:  if (lastEdge) nextState = ST_RD_WAIT;
      ST_WR_COMMIT: nextState = ST_WR_SHIFT;
`else
      ST_RD_SHIFT:  if (lastEdge) nextState = ST_DONE;
      ST_WR_COMMIT: nextState = ST_DONE;
`endif
      ST_WR_SHIFT:  if (lastEdge) nextState = ST_WR_COMMIT;
      ST_DONE:      if (bus.cs_n) nextState = ST_IDLE;
      default:      nextState = ST_IDLE;
    endcase
    if (abort) nextState = ST_IDLE;
  end

  // Outputs are registered off nextState so they line up with the state they
  // describe; a tick keeps LEFT mode even when that edge exits the shift state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      latCnt    <= '0;
      srModeQ   <= SR_HOLD;
      srTickQ   <= 1'b0;
      addrWeQ   <= 1'b0;
      dmWeQ     <= 1'b0;
      misoOeQ   <= 1'b0;
      frameErrQ <= 1'b0;
`ifdef SPI_FSM_BURST_EN
      addrIncQ  <= 1'b0;
`endif
    end else begin
      state     <= nextState;
      latCnt    <= (state == ST_RD_WAIT && nextState == ST_RD_WAIT) ? latCnt + 1'b1 : '0;
      srModeQ   <= cntEn ? SR_LEFT : modeOf(nextState);
      srTickQ   <= cntEn || (nextState == ST_RD_LOAD);
      addrWeQ   <= (nextState == ST_DECODE);
      dmWeQ     <= (nextState == ST_WR_COMMIT);
      misoOeQ   <= (nextState == ST_RD_SHIFT);
      frameErrQ <= abort && !errQuiet;
`ifdef SPI_FSM_BURST_EN
      addrIncQ  <= (nextState == ST_WR_COMMIT) ||
                   (state == ST_RD_SHIFT && nextState == ST_RD_WAIT);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) assert (bitCount < CW'(WIDTH));
  end

  assign bus.sr_mode   = srModeQ;
  assign bus.sr_tick   = srTickQ;
  assign bus.addr_we   = addrWeQ;
  assign bus.dm_we     = dmWeQ;
  assign bus.miso_oe   = misoOeQ;
  assign bus.frame_err = frameErrQ;
endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm (MEM_LAT=2); burst checks run when SPI_FSM_BURST_EN is defined.
module tb_spi_fsm;
  logic clk = 1'b0;
  logic resetN;

  spi_fsm_if bus();

  spi_fsm #(.WIDTH(8), .MEM_LAT(2)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  int unsigned tickCnt, addrWeCnt, dmWeCnt, frameErrCnt, incCnt;

  always @(negedge clk) begin
    if (resetN) begin
      if (bus.sr_tick)   tickCnt++;
      if (bus.addr_we)   addrWeCnt++;
      if (bus.dm_we)     dmWeCnt++;
      if (bus.frame_err) frameErrCnt++;
`ifdef SPI_FSM_BURST_EN
      if (bus.addr_inc)  incCnt++;
`endif
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearCounts();
    tickCnt = 0; addrWeCnt = 0; dmWeCnt = 0; frameErrCnt = 0; incCnt = 0;
  endtask

  // Apply inputs for one clk, return just after the edge that consumed them.
  task automatic step(input logic cs, input logic sp);
    @(negedge clk);
    bus.cs_n         = cs;
    bus.sclk_posedge = sp;
    @(posedge clk);
    #1;
  endtask

  // n SCLK pulses spaced 3 clks apart; returns right after the last one.
  task automatic sendBits(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
      end
      step(1'b0, 1'b1);
    end
  endtask

  task automatic pad(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clearCounts();
    bus.cs_n = 1'b1; bus.sclk_posedge = 1'b0; bus.rw_bit = 1'b0;
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_mode", 32'(bus.sr_mode), 32'h0);
    checkEq("rst_outs", 32'({bus.sr_tick, bus.addr_we, bus.dm_we, bus.miso_oe, bus.frame_err}), 32'h0);
    @(negedge clk) resetN = 1'b1;

    // Reset asserted mid-ADDR clears registered outputs without waiting for a clock.
    step(1'b0, 1'b0);
    sendBits(3);
    checkEq("addr_tick_before_rst", 32'({bus.sr_tick, bus.sr_mode}), 32'b1_10);
    #1 resetN = 1'b0;
    #1;
    checkEq("async_rst_mode", 32'(bus.sr_mode), 32'h0);
    checkEq("async_rst_outs", 32'({bus.sr_tick, bus.addr_we, bus.dm_we, bus.miso_oe, bus.frame_err}), 32'h0);
    @(negedge clk) begin resetN = 1'b1; bus.cs_n = 1'b1; end
    step(1'b1, 1'b0);
    checkEq("post_rst_idle", 32'({bus.frame_err, bus.sr_mode}), 32'h0);

    // Write frame: address 7'h2A, rw=0, then one data byte.
    clearCounts();
    bus.rw_bit = 1'b0;
    step(1'b0, 1'b0);
    sendBits(8);
    checkEq("wr_addr_we", 32'(bus.addr_we), 32'h1);
    step(1'b0, 1'b0);
    checkEq("wr_addr_we_end", 32'({bus.addr_we, bus.sr_mode}), 32'b0_10);
    pad(5);
    sendBits(8);
    checkEq("wr_dm_we", 32'(bus.dm_we), 32'h1);
    step(1'b0, 1'b0);
    checkEq("wr_dm_we_end", 32'(bus.dm_we), 32'h0);
    step(1'b1, 1'b0);
    checkEq("wr_no_frame_err", 32'(bus.frame_err), 32'h0);
    step(1'b1, 1'b0);
    checkEq("wr_ticks", tickCnt, 32'd16);
    checkEq("wr_pulses", 32'({addrWeCnt[3:0], dmWeCnt[3:0], frameErrCnt[3:0]}), 32'h110);

    // Read frame: address 7'h05, rw=1, two wait clks, load, eight shift edges.
    clearCounts();
    bus.rw_bit = 1'b1;
    step(1'b0, 1'b0);
    sendBits(8);
    checkEq("rd_addr_we", 32'(bus.addr_we), 32'h1);
    step(1'b0, 1'b0);
    checkEq("rd_wait1", 32'({bus.sr_tick, bus.sr_mode, bus.addr_we}), 32'b0_00_0);
    step(1'b0, 1'b0);
    checkEq("rd_wait2", 32'({bus.sr_tick, bus.sr_mode}), 32'b0_00);
    step(1'b0, 1'b0);
    checkEq("rd_load", 32'({bus.sr_tick, bus.sr_mode, bus.miso_oe}), 32'b1_11_0);
    step(1'b0, 1'b0);
    checkEq("rd_shift_entry", 32'({bus.sr_tick, bus.sr_mode, bus.miso_oe}), 32'b0_10_1);
    bus.rw_bit = 1'b0;
    pad(2);
    sendBits(7);
    checkEq("rd_miso_7th", 32'(bus.miso_oe), 32'h1);
    pad(2);
    step(1'b0, 1'b1);
    checkEq("rd_miso_8th", 32'({bus.miso_oe, bus.sr_tick}), 32'b0_1);
    step(1'b0, 1'b0);
    checkEq("rd_done_mode", 32'({bus.sr_mode, bus.miso_oe}), 32'b00_0);
    step(1'b1, 1'b0);
    checkEq("rd_no_frame_err", 32'(bus.frame_err), 32'h0);
    step(1'b1, 1'b0);
    checkEq("rd_ticks", tickCnt, 32'd17);
    checkEq("rd_pulses", 32'({addrWeCnt[3:0], dmWeCnt[3:0]}), 32'h10);

    // Abort after 5 write-data edges, then a clean frame.
    clearCounts();
    step(1'b0, 1'b0);
    sendBits(8);
    pad(5);
    sendBits(5);
    step(1'b1, 1'b0);
    checkEq("abort_frame_err", 32'({bus.frame_err, bus.dm_we}), 32'b1_0);
    step(1'b1, 1'b0);
    checkEq("abort_err_width", 32'(bus.frame_err), 32'h0);
    checkEq("abort_counts", 32'({dmWeCnt[3:0], frameErrCnt[3:0]}), 32'h01);
    step(1'b0, 1'b0);
    sendBits(8);
    checkEq("reframe_addr_we", 32'(bus.addr_we), 32'h1);
    pad(5);
    sendBits(8);
    checkEq("reframe_dm_we", 32'(bus.dm_we), 32'h1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checkEq("reframe_counts", 32'({dmWeCnt[3:0], frameErrCnt[3:0]}), 32'h11);

    // cs_n rise together with an SCLK pulse in ADDR: edge dropped, frame error.
    clearCounts();
    step(1'b0, 1'b0);
    sendBits(3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    checkEq("simul_tick", 32'(bus.sr_tick), 32'h0);
    checkEq("simul_frame_err", 32'(bus.frame_err), 32'h1);
    step(1'b1, 1'b0);
    checkEq("simul_ticks", tickCnt, 32'd3);

`ifdef SPI_FSM_BURST_EN
    // Three-byte write burst terminated by cs_n between bytes.
    clearCounts();
    bus.rw_bit = 1'b0;
    step(1'b0, 1'b0);
    sendBits(8);
    pad(5);
    for (int unsigned b = 0; b < 3; b++) begin
      sendBits(8);
      checkEq("burst_dm_inc", 32'({bus.dm_we, bus.addr_inc}), 32'b11);
      pad(2);
    end
    step(1'b1, 1'b0);
    checkEq("burst_end_no_err", 32'(bus.frame_err), 32'h0);
    step(1'b1, 1'b0);
    checkEq("burst_counts", 32'({dmWeCnt[3:0], incCnt[3:0], frameErrCnt[3:0]}), 32'h330);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
